// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C constants and slave receiver state encoding
package i2c_pkg;

   localparam int I2C_ADDR_W        = 7;
   localparam bit I2C_RW_WRITE      = 1'b0;
   localparam int I2C_BITS_PER_BYTE = 8;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ACK_ADDR,
      DATA,
      ACK_DATA,
      IGNORE
   } i2c_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - async line synchronizer with previous-sample edge detect
module i2c_line_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic line_in,
   output logic line_s,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Reset to the idle-bus level so releasing reset never looks like an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], line_in};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign line_s = sync_q[STAGES-1];
   assign rise   = !prev_q & line_s;
   assign fall   = prev_q & !line_s;

endmodule

// File: rtl/i2c_slave_rx.sv
// rtl/i2c_slave_rx.sv - write-only I2C slave receiver with address match and ACK
module i2c_slave_rx
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       addressed,
   output logic       start_det,
   output logic       stop_det
);

   logic scl_s, scl_rise, scl_fall;
   logic sda_s, sda_rise, sda_fall;

   i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
      .clk     (clk),
      .reset   (reset),
      .line_in (scl_in),
      .line_s  (scl_s),
      .rise    (scl_rise),
      .fall    (scl_fall)
   );

   i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
      .clk     (clk),
      .reset   (reset),
      .line_in (sda_in),
      .line_s  (sda_s),
      .rise    (sda_rise),
      .fall    (sda_fall)
   );

   // SCL held high across two samples; an SCL edge in the same cycle disqualifies START/STOP.
   logic scl_held_high, start_cond, stop_cond;
   assign scl_held_high = scl_s & !scl_rise;
   assign start_cond    = scl_held_high & sda_fall;
   assign stop_cond     = scl_held_high & sda_rise;

   localparam logic [3:0] LAST_BIT = 4'(I2C_BITS_PER_BYTE - 1);

   i2c_state_t state, state_n;
   logic [3:0] bit_cnt, bit_cnt_n;
   logic [7:0] shift_q, shift_n, shifted;
   logic       sda_oe_n, addressed_n, rx_valid_n, start_det_n, stop_det_n;
   logic [7:0] rx_data_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_q   <= '0;
         sda_oe    <= 1'b0;
         addressed <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shift_q   <= shift_n;
         sda_oe    <= sda_oe_n;
         addressed <= addressed_n;
         rx_data   <= rx_data_n;
         rx_valid  <= rx_valid_n;
         start_det <= start_det_n;
         stop_det  <= stop_det_n;
      end
   end

   always_comb begin
      state_n     = state;
      bit_cnt_n   = bit_cnt;
      shift_n     = shift_q;
      sda_oe_n    = sda_oe;
      addressed_n = addressed;
      rx_data_n   = rx_data;
      rx_valid_n  = 1'b0;
      start_det_n = 1'b0;
      stop_det_n  = 1'b0;
      shifted     = {shift_q[6:0], sda_s};

      if (start_cond) begin
         state_n     = ADDR;
         bit_cnt_n   = '0;
         shift_n     = '0;
         sda_oe_n    = 1'b0;
         addressed_n = 1'b0;
         start_det_n = 1'b1;
      end else if (stop_cond) begin
         state_n     = IDLE;
         sda_oe_n    = 1'b0;
         addressed_n = 1'b0;
         stop_det_n  = 1'b1;
      end else begin
         case (state)
            IDLE: ;
            ADDR: begin
               if (scl_rise) begin
                  shift_n   = shifted;
                  bit_cnt_n = bit_cnt + 4'd1;
                  if (bit_cnt == LAST_BIT) begin
                     if (shifted[7:1] == SLAVE_ADDR && shifted[0] == I2C_RW_WRITE)
                        state_n = ACK_ADDR;
                     else
                        state_n = IGNORE;
                  end
               end
            end
            // sda_oe itself tells which of the two falls around the 9th clock this is.
            ACK_ADDR: begin
               if (scl_fall) begin
                  if (!sda_oe) begin
                     sda_oe_n    = 1'b1;
                     addressed_n = 1'b1;
                  end else begin
                     sda_oe_n  = 1'b0;
                     bit_cnt_n = '0;
                     state_n   = DATA;
                  end
               end
            end
            DATA: begin
               if (scl_rise) begin
                  shift_n   = shifted;
                  bit_cnt_n = bit_cnt + 4'd1;
                  if (bit_cnt == LAST_BIT) begin
                     rx_data_n  = shifted;
                     rx_valid_n = 1'b1;
                     state_n    = ACK_DATA;
                  end
               end
            end
            ACK_DATA: begin
               if (scl_fall) begin
                  if (!sda_oe) begin
                     sda_oe_n = 1'b1;
                  end else begin
                     sda_oe_n  = 1'b0;
                     bit_cnt_n = '0;
                     state_n   = DATA;
                  end
               end
            end
            IGNORE:  sda_oe_n = 1'b0;
            default: state_n  = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb/tb_i2c_slave_rx.sv - scoreboard bench driving an I2C master onto i2c_slave_rx
module tb_i2c_slave_rx;

   localparam int L = 4;
   localparam int H = 8;
   localparam int EVT_START = 1;
   localparam int EVT_STOP  = 2;

   typedef struct packed {
      logic ack;
      logic addr;
   } ack_t;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       scl_in, sda_in, sda_oe, rx_valid, addressed, start_det, stop_det;
   logic [7:0] rx_data;

   assign scl_in = m_scl;
   assign sda_in = m_sda & ~sda_oe;

   i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .scl_in    (scl_in),
      .sda_in    (sda_in),
      .sda_oe    (sda_oe),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .addressed (addressed),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] exp_data[$];
   int         exp_evt[$];
   ack_t       exp_ack[$];
   ack_t       cur_ack;
   int         cur_evt;
   logic       ack_slot = 1'b0;
   logic       ack_seen = 1'b0;
   logic       prev_valid = 1'b0, prev_start = 1'b0, prev_stop = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (rx_valid) begin
         chk("rx_valid single-cycle", {30'd0, prev_valid, rx_valid}, 32'd1);
         if (exp_data.size() == 0) chk("unexpected rx_valid, rx_data", {24'd0, rx_data}, 32'hFFFF_FFFF);
         else chk("rx_data", {24'd0, rx_data}, {24'd0, exp_data.pop_front()});
      end
      if (start_det) begin
         chk("start_det single-cycle", {30'd0, prev_start, start_det}, 32'd1);
         chk("addressed at start_det", {31'd0, addressed}, 32'd0);
         cur_evt = (exp_evt.size() == 0) ? 0 : exp_evt.pop_front();
         chk("start_det event", EVT_START, cur_evt);
      end
      if (stop_det) begin
         chk("stop_det single-cycle", {30'd0, prev_stop, stop_det}, 32'd1);
         chk("addressed at stop_det", {31'd0, addressed}, 32'd0);
         cur_evt = (exp_evt.size() == 0) ? 0 : exp_evt.pop_front();
         chk("stop_det event", EVT_STOP, cur_evt);
      end
      if (ack_slot && !ack_seen) begin
         ack_seen = 1'b1;
         if (exp_ack.size() == 0) begin
            chk("unexpected ack slot", 32'd0, 32'd1);
         end else begin
            cur_ack = exp_ack.pop_front();
            chk("sda_oe in 9th clock", {31'd0, sda_oe}, {31'd0, cur_ack.ack});
            chk("addressed in 9th clock", {31'd0, addressed}, {31'd0, cur_ack.addr});
         end
      end
      if (!ack_slot) ack_seen = 1'b0;
      prev_valid = rx_valid;
      prev_start = start_det;
      prev_stop  = stop_det;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_start();
      m_sda = 1'b1;
      wait_cyc(L);
      m_scl = 1'b1;
      wait_cyc(H);
      exp_evt.push_back(EVT_START);
      m_sda = 1'b0;
      wait_cyc(H);
      m_scl = 1'b0;
      wait_cyc(L);
   endtask

   task automatic send_stop();
      m_sda = 1'b0;
      wait_cyc(L);
      m_scl = 1'b1;
      wait_cyc(H);
      exp_evt.push_back(EVT_STOP);
      m_sda = 1'b1;
      wait_cyc(H);
   endtask

   task automatic send_bit(input logic b);
      m_sda = b;
      wait_cyc(L);
      m_scl = 1'b1;
      wait_cyc(H);
      m_scl = 1'b0;
      wait_cyc(L);
   endtask

   task automatic send_bits(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic ack_clock(input logic ack, input logic addr);
      exp_ack.push_back('{ack: ack, addr: addr});
      m_sda = 1'b1;
      wait_cyc(L);
      m_scl = 1'b1;
      wait_cyc(4);
      ack_slot = 1'b1;
      wait_cyc(2);
      ack_slot = 1'b0;
      wait_cyc(H - 6);
      m_scl = 1'b0;
      wait_cyc(L);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic ack, input logic addr,
                            input logic is_data);
      if (is_data) exp_data.push_back(b);
      send_bits(b);
      ack_clock(ack, addr);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish, checks %0d", n_checks);
      $fatal(1);
   end

   initial begin
      wait_cyc(5);
      chk("reset sda_oe", {31'd0, sda_oe}, 32'd0);
      chk("reset rx_data", {24'd0, rx_data}, 32'd0);
      chk("reset rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("reset addressed", {31'd0, addressed}, 32'd0);
      chk("reset start_det", {31'd0, start_det}, 32'd0);
      chk("reset stop_det", {31'd0, stop_det}, 32'd0);
      reset = 1'b0;
      wait_cyc(10);

      // 0x50 write, one byte
      send_start();
      send_byte(8'hA0, 1'b1, 1'b1, 1'b0);
      send_byte(8'hAA, 1'b1, 1'b1, 1'b1);
      chk("addressed before stop", {31'd0, addressed}, 32'd1);
      send_stop();
      wait_cyc(4);
      chk("rx_data held after stop", {24'd0, rx_data}, 32'hAA);

      // wrong address 0x51
      send_start();
      send_byte(8'hA2, 1'b0, 1'b0, 1'b0);
      send_byte(8'h55, 1'b0, 1'b0, 1'b0);
      send_stop();

      // 0x50 read is NACKed and ignored
      send_start();
      send_byte(8'hA1, 1'b0, 1'b0, 1'b0);
      send_byte(8'h77, 1'b0, 1'b0, 1'b0);
      send_stop();

      // three bytes
      send_start();
      send_byte(8'hA0, 1'b1, 1'b1, 1'b0);
      send_byte(8'h12, 1'b1, 1'b1, 1'b1);
      send_byte(8'h34, 1'b1, 1'b1, 1'b1);
      send_byte(8'hFF, 1'b1, 1'b1, 1'b1);
      send_stop();

      // partial byte dropped by repeated START
      send_start();
      send_byte(8'hA0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(i[0] == 1'b0);
      send_start();
      send_byte(8'hA0, 1'b1, 1'b1, 1'b0);
      send_byte(8'h3C, 1'b1, 1'b1, 1'b1);
      send_stop();

      // reset while the data ACK is being driven
      send_start();
      send_byte(8'hA0, 1'b1, 1'b1, 1'b0);
      exp_data.push_back(8'h99);
      send_bits(8'h99);
      wait_cyc(1);
      chk("sda_oe before mid-ACK reset", {31'd0, sda_oe}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("sda_oe async drop", {31'd0, sda_oe}, 32'd0);
      chk("addressed in reset", {31'd0, addressed}, 32'd0);
      chk("rx_data in reset", {24'd0, rx_data}, 32'd0);
      chk("rx_valid in reset", {31'd0, rx_valid}, 32'd0);
      m_scl = 1'b1;
      m_sda = 1'b1;
      wait_cyc(4);
      reset = 1'b0;
      wait_cyc(40);

      chk("data queue drained", exp_data.size(), 32'd0);
      chk("event queue drained", exp_evt.size(), 32'd0);
      chk("ack queue drained", exp_ack.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
Write-only I2C slave receiver, downstream of the I2C master on the same bus. Runs on the system clock and oversamples SCL/SDA. Detects START/STOP, matches a 7-bit address, and ACKs by pulling SDA low. Each received data byte is presented on a one-cycle valid strobe.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit address this slave answers to
SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (min 2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
scl_in  input  1  I2C SCL line level (async)
sda_in  input  1  I2C SDA line level (async)
sda_oe  output  1  1 = drive SDA low (ACK); 0 = release
rx_data  output  8  last received data byte, MSB first on bus
rx_valid  output  1  one-cycle pulse, rx_data updated
addressed  output  1  high from address ACK until STOP/START
start_det  output  1  one-cycle pulse on START or repeated START
stop_det  output  1  one-cycle pulse on STOP

Behaviour:
- Reset (async, active-high): sda_oe=0, rx_data=8'h00, rx_valid=0, addressed=0, start_det=0, stop_det=0, state=IDLE, bit count=0.
- Sync flops reset to 1 (idle bus), so no false edge is seen on reset release.
- Sampling: scl_s/sda_s are the SYNC_STAGES-synchronized lines. prev copies are held one cycle. scl_rise = !prev_scl & scl_s. scl_fall = prev_scl & !scl_s.
- START: prev_scl & scl_s & prev_sda & !sda_s. STOP: prev_scl & scl_s & !prev_sda & sda_s.
- If SCL and SDA change in the same sampled cycle, it is not START/STOP. The SCL edge is processed normally.
- START and STOP are accepted in every state and take priority over the state logic.
  - START: go to ADDR, clear count and shift register, sda_oe=0, addressed=0, start_det pulse.
  - STOP: go to IDLE, sda_oe=0, addressed=0, stop_det pulse. A partial byte is discarded with no rx_valid.
- Data is sampled on scl_rise, MSB first. The 8-bit shift register and a 0..8 count are shared by address and data bytes.
- States:
  - IDLE: wait for START.
  - ADDR: shift on scl_rise. After the 8th bit (addr[6:0], R/W):
    - If match and R/W=0, go to ACK_ADDR.
    - Otherwise go to IGNORE. R/W=1 (read) is NACKed; reads are unsupported.
  - ACK_ADDR:
    - First scl_fall: sda_oe=1, addressed=1.
    - Next scl_fall (end of 9th clock): sda_oe=0, count=0, go to DATA.
  - DATA: shift on scl_rise. On the 8th bit: rx_data<=shifted byte, rx_valid pulses the next cycle, go to ACK_DATA.
  - ACK_DATA:
    - First scl_fall: sda_oe=1.
    - Next scl_fall: sda_oe=0, count=0, go back to DATA.
  - IGNORE: sda_oe=0, no outputs. Leave only on START or STOP.
- Latency: rx_valid is high exactly SYNC_STAGES+1 clk cycles after the 8th data-bit SCL rise reaches scl_in.
- Every byte is ACKed; there is no backpressure and no clock stretching.
- rx_data holds its value until the next complete byte.
- rx_valid, start_det and stop_det are single-cycle pulses, never high two cycles in a row.
- Precondition: the SCL high and low phases must each be at least SYNC_STAGES+2 clk cycles. Faster buses are out of spec.

Decomposition:
- Package i2c_pkg:
  - state enum (IDLE, ADDR, ACK_ADDR, DATA, ACK_DATA, IGNORE)
  - I2C_ADDR_W=7
  - I2C_RW_WRITE=1'b0
  - I2C_BITS_PER_BYTE=8
  - The master shares these constants.
- Sub-module i2c_line_sync: parameterized synchronizer plus previous-sample register with rise/fall outputs. Instantiated once for SCL and once for SDA.

Test Plan:
- START, addr 0x50 W, byte 0xAA, STOP → sda_oe high during both 9th clocks; one rx_valid with rx_data=0xAA; addressed high from first ACK until STOP.
- START, addr 0x51 W, byte 0x55 → sda_oe never asserted; no rx_valid; addressed=0.
- START, addr 0x50 R → address NACKed (sda_oe stays 0); IGNORE until STOP; stop_det pulses.
- START, 0x50 W, bytes 0x12, 0x34, 0xFF, STOP → three rx_valid pulses carrying 0x12, 0x34, 0xFF in order, each ACKed.
- START, 0x50 W, 4 bits of a byte, repeated START, 0x50 W, 0x3C → partial byte dropped; two start_det pulses; single rx_valid with 0x3C.
- Reset asserted mid-DATA while sda_oe=1 → sda_oe drops asynchronously, all outputs return to reset values. After release with the bus idle, no start_det/stop_det spurious pulse.
